sram_ctrl: RTL
==============

// Module: sram_ctrl
// PURPOSE
// - Memory-side target of the arbiter: accepts its addr/mask/enable/cmd/wdata bus, returns data/valid.
// - Drives an external asynchronous 16-bit SRAM; each 32-bit access is split into two half-word accesses (low first).
// - Writes are posted into a FIFO (the arbiter pulses write enable for one cycle with no handshake).
// - Reads are answered with a one-cycle valid pulse.
// PARAMETERS
// - SRAM_AW      18  SRAM half-word address width; addr[SRAM_AW:1] used, upper bits ignored (alias)
// - WAIT_CYCLES  1   extra strobe cycles per half access (0..15); strobe window = WAIT_CYCLES+1 cycles
// - WBUF_DEPTH   4   posted-write FIFO entries (power of 2, >=2); entry = {addr[SRAM_AW:2], mask, wdata}
// PORTS
// - clk            in   1        clock
// - reset          in   1        synchronous, active-high reset
// - addr           in   32       byte address from arbiter; bits [1:0] ignored
// - mask           in   4        write byte mask, bit i = byte i
// - enable         in   1        request valid
// - cmd            in   1        `MEM_CMD_READ / `MEM_CMD_WRITE (consts.vh)
// - wdata          in   32       write data
// - data           out  32       read data {hi,lo}, registered, held until next read completes
// - valid          out  1        one-cycle pulse: read data ready
// - busy           out  1        FSM not IDLE or FIFO non-empty
// - wbuf_overflow  out  1        sticky: write dropped because FIFO full; cleared only by reset
// - sram_addr      out  SRAM_AW  half-word address
// - sram_dq_o      out  16       write data to pad
// - sram_dq_i      in   16       read data from pad
// - sram_dq_oe     out  1        pad output enable
// - sram_ce_n / sram_oe_n / sram_we_n / sram_lb_n / sram_ub_n  out  1 each  active-low strobes
// BEHAVIOUR
// - Reset: data=0, valid=0, busy=0, wbuf_overflow=0, FIFO empty, FSM IDLE, all strobes high, dq_oe=0, sram_addr=0.
// - Reset mid-access: strobes high the cycle after the reset edge; in-flight and queued writes discarded.
// - Push: enable && cmd==WRITE, any state -> enqueue. Full and no pop this cycle -> drop, set wbuf_overflow.
//   Full with pop in same cycle -> push accepted.
// - Reads: enable && cmd==READ is sampled only in IDLE with FIFO empty; the arbiter holds enable.
//   Queued writes always drain before a read (strict ordering, no forwarding).
// - FSM: IDLE, WR_LO, WR_LO_REC, WR_HI, WR_HI_REC, RD_LO, RD_HI, RD_DONE.
// - IDLE: FIFO non-empty -> pop into a working reg, go WR_LO; else read request -> latch addr, go RD_LO; else stay.
// - WR_x: WAIT_CYCLES+1 cycles; ce_n=0, we_n=0, dq_oe=1, lb_n/ub_n = ~mask bits of that half.
// - WR_x_REC: 1 cycle; we_n=1, ce_n=0, addr and dq held (hold time). After WR_HI_REC go IDLE.
// - RD_x: WAIT_CYCLES+1 cycles; ce_n=0, oe_n=0, lb_n=ub_n=0, dq_oe=0; sram_dq_i captured on the last cycle.
// - RD_DONE: data updated, valid=1 for exactly 1 cycle, then IDLE.
// - The arbiter drops enable the following cycle; no re-issue.
// - Half address: lo={addr[SRAM_AW:2],1'b0}, hi={addr[SRAM_AW:2],1'b1}.
// - Lane mapping: lo half <- bytes 1:0, hi half <- bytes 3:2.
// - Read latency: enable sampled in IDLE -> valid 2*(WAIT_CYCLES+1)+1 cycles later (5 at default).
// - Write occupancy per word: 2*(WAIT_CYCLES+2) cycles (6 at default).
// - Strobes decode combinationally from the state register and working regs; a wait counter (4 bits) times the strobe window.
// - FIFO pointers: log2(WBUF_DEPTH)+1 bits; full/empty by MSB compare; wrap-around naturally.
// CONFIGURATION
// - MEMCTL_HALF_SKIP_EN defined: a write half whose two mask bits are 0 is skipped entirely.
//   Its WR_x and WR_x_REC states are bypassed; mask 4'b0000 pops and returns to IDLE in 1 cycle with no strobe.
// - Undefined: both halves are always sequenced; a half with mask 00 runs with lb_n=ub_n=1 (no bytes written).
// TESTING
// - Read addr=0x0000_0010 with SRAM model [0x8]=0xBEEF, [0x9]=0xDEAD, WAIT_CYCLES=1
//   -> valid high exactly 5 cycles after enable, data=0xDEADBEEF.
// - Write addr=0x14, wdata=0x11223344, mask=4'b1111, then read 0x14 (enable held)
//   -> write completes first (lo=0x3344, hi=0x1122); then data=0x11223344.
// - Write mask=4'b0100, wdata=0x00AB0000
//   -> hi half lb_n=0, ub_n=1; skip-EN: no lo strobe; non-skip: lo half with lb_n=ub_n=1; memory elsewhere unchanged.
// - 5 back-to-back write pulses, 2 cycles apart, WBUF_DEPTH=4
//   -> all 5 land in order (pop frees a slot); 6 pulses 1 cycle apart -> wbuf_overflow=1, 6th dropped.
// - Assert reset during RD_HI -> next cycle strobes high, valid=0, busy=0.
//   A following read returns correct data with standard latency.

Source files
------------

// File: rtl/sram_ctrl.sv
// sram_ctrl: memory-side target of the arbiter driving a 16-bit asynchronous SRAM.
// Each 32-bit access becomes two half-word accesses, low half first.
// Writes are posted into a small FIFO. Reads wait until the FIFO has drained
// and are answered with a one-cycle valid pulse.
// Optional build macro: MEMCTL_HALF_SKIP_EN. When it is defined, a write half whose
// two mask bits are both zero is skipped completely.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   addr/mask/enable/cmd  request bus from the arbiter (addr[1:0] ignored)
//   wdata                 write data
//   data/valid            read data {hi,lo} and its one-cycle ready pulse
//   busy                  FSM active or writes still queued
//   wbuf_overflow         sticky flag: a write was dropped because the FIFO was full
//   sram_*                SRAM pads (address, dq in/out/oe, active-low strobes)

`ifndef MEM_CMD_READ
`define MEM_CMD_READ 1'b0
`endif
`ifndef MEM_CMD_WRITE
`define MEM_CMD_WRITE 1'b1
`endif

module sram_ctrl #(
    parameter int unsigned SRAM_AW     = 18,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned WBUF_DEPTH  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        addr,
    input  logic [3:0]         mask,
    input  logic               enable,
    input  logic               cmd,
    input  logic [31:0]        wdata,
    output logic [31:0]        data,
    output logic               valid,
    output logic               busy,
    output logic               wbuf_overflow,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_o,
    input  logic [15:0]        sram_dq_i,
    output logic               sram_dq_oe,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic               sram_lb_n,
    output logic               sram_ub_n
);

    localparam int unsigned PTR_W = $clog2(WBUF_DEPTH);
    localparam int unsigned WA_W  = SRAM_AW - 1;
    localparam int unsigned ENT_W = WA_W + 4 + 32;
    localparam logic [3:0]   WAIT_LAST = 4'(WAIT_CYCLES);
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);

`ifdef MEMCTL_HALF_SKIP_EN
    localparam bit HALF_SKIP = 1'b1;
`else
    localparam bit HALF_SKIP = 1'b0;
`endif

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WR_LO     = 3'd1;
    localparam logic [2:0] S_WR_LO_REC = 3'd2;
    localparam logic [2:0] S_WR_HI     = 3'd3;
    localparam logic [2:0] S_WR_HI_REC = 3'd4;
    localparam logic [2:0] S_RD_LO     = 3'd5;
    localparam logic [2:0] S_RD_HI     = 3'd6;
    localparam logic [2:0] S_RD_DONE   = 3'd7;

    logic [2:0]       state, state_nxt;
    logic [3:0]       wait_cnt;
    logic [PTR_W:0]   wr_ptr, rd_ptr;
    logic [ENT_W-1:0] fifo_mem [WBUF_DEPTH];
    logic [WA_W-1:0]  work_addr;
    logic [3:0]       work_mask;
    logic [31:0]      work_data;
    logic [15:0]      lo_data;

    logic             empty, full, wait_last, pop, push_req, push, rd_req;
    logic [ENT_W-1:0] head;
    logic [WA_W-1:0]  head_addr;
    logic [3:0]       head_mask;
    logic [31:0]      head_data;
    logic             hi_sel, wr_phase, rd_phase;
    logic [1:0]       lanes;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^{addr[31:SRAM_AW+1], addr[1:0]};

    // FIFO status; pointers carry one extra wrap bit
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

    assign head      = fifo_mem[rd_ptr[PTR_W-1:0]];
    assign head_addr = head[ENT_W-1 -: WA_W];
    assign head_mask = head[35:32];
    assign head_data = head[31:0];

    assign wait_last = (wait_cnt == WAIT_LAST);
    assign pop       = (state == S_IDLE) && !empty;
    assign push_req  = enable && (cmd == `MEM_CMD_WRITE);
    // A push into a full FIFO still fits when a pop happens in the same cycle
    assign push      = push_req && (!full || pop);
    assign rd_req    = (state == S_IDLE) && empty && enable && (cmd == `MEM_CMD_READ);
    assign busy      = (state != S_IDLE) || !empty;

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (pop) begin
                    if (HALF_SKIP && (head_mask[1:0] == 2'b00))
                        state_nxt = (head_mask[3:2] == 2'b00) ? S_IDLE : S_WR_HI;
                    else
                        state_nxt = S_WR_LO;
                end else if (rd_req) begin
                    state_nxt = S_RD_LO;
                end
            end
            S_WR_LO:     if (wait_last) state_nxt = S_WR_LO_REC;
            S_WR_LO_REC: state_nxt = (HALF_SKIP && (work_mask[3:2] == 2'b00)) ? S_IDLE : S_WR_HI;
            S_WR_HI:     if (wait_last) state_nxt = S_WR_HI_REC;
            S_WR_HI_REC: state_nxt = S_IDLE;
            S_RD_LO:     if (wait_last) state_nxt = S_RD_HI;
            S_RD_HI:     if (wait_last) state_nxt = S_RD_DONE;
            S_RD_DONE:   state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // Pad decode from the state register and working registers
    assign hi_sel   = (state == S_WR_HI) || (state == S_WR_HI_REC) || (state == S_RD_HI);
    assign wr_phase = (state == S_WR_LO) || (state == S_WR_LO_REC) ||
                      (state == S_WR_HI) || (state == S_WR_HI_REC);
    assign rd_phase = (state == S_RD_LO) || (state == S_RD_HI);
    assign lanes    = hi_sel ? work_mask[3:2] : work_mask[1:0];

    assign sram_addr  = {work_addr, hi_sel};
    assign sram_dq_o  = hi_sel ? work_data[31:16] : work_data[15:0];
    assign sram_dq_oe = wr_phase;
    assign sram_ce_n  = !(wr_phase || rd_phase);
    assign sram_we_n  = !((state == S_WR_LO) || (state == S_WR_HI));
    assign sram_oe_n  = !rd_phase;
    assign sram_lb_n  = wr_phase ? !lanes[0] : !rd_phase;
    assign sram_ub_n  = wr_phase ? !lanes[1] : !rd_phase;

    // State, pointers, working registers and read return
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            wait_cnt      <= 4'd0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            work_addr     <= '0;
            work_mask     <= 4'd0;
            work_data     <= 32'd0;
            lo_data       <= 16'd0;
            data          <= 32'd0;
            valid         <= 1'b0;
            wbuf_overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= (state_nxt == state) ? wait_cnt + 4'd1 : 4'd0;
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop) begin
                rd_ptr    <= rd_ptr + PTR_ONE;
                work_addr <= head_addr;
                work_mask <= head_mask;
                work_data <= head_data;
            end
            if (rd_req)
                work_addr <= addr[SRAM_AW:2];
            if (push_req && full && !pop)
                wbuf_overflow <= 1'b1;
            if ((state == S_RD_LO) && wait_last)
                lo_data <= sram_dq_i;
            valid <= (state == S_RD_HI) && wait_last;
            if ((state == S_RD_HI) && wait_last)
                data <= {sram_dq_i, lo_data};
        end
    end

    // FIFO storage has no reset: an entry is only read after it has been written
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr[PTR_W-1:0]] <= {addr[SRAM_AW:2], mask, wdata};
    end

endmodule
